seq_alu: RTL
============

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the operand/result width; legal values are 32 and 64.
REQ-002 SHALL have parameter OP_WIDTH, default 5, giving the op code width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: request present.
REQ-006 SHALL have port in_ready, output, 1 bit: the unit accepts a request.
REQ-007 SHALL have port a, input, XLEN bits: operand A.
REQ-008 SHALL have port b, input, XLEN bits: operand B.
REQ-009 SHALL have port op, input, OP_WIDTH bits: operation code.
REQ-010 SHALL have port word, input, 1 bit: 32-bit word mode; ignored when XLEN=32.
REQ-011 SHALL have port kill, input, 1 bit: synchronous abort.
REQ-012 SHALL have port out_valid, output, 1 bit: result present.
REQ-013 SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 SHALL have port res, output, XLEN bits: registered result.
REQ-015 SHALL have port zero, output, 1 bit: high when res is all zeros.

Function
REQ-016 SHALL decode op as follows:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA
- 8 SLT (signed), 9 SLTU, 10 COPY_A, 11 COPY_B, 12 JALR ((a+b) with bit0 cleared)
- 13 MUL (low half), 14 MULH (s*s high), 15 MULHU (u*u high)
- 16 DIV, 17 DIVU, 18 REM, 19 REMU
REQ-017 SHALL treat other op values as ADD and set no other side effect.
REQ-018 SHALL run a three-state FSM:
- IDLE: in_ready=1.
- BUSY: iterating; in_ready=0, out_valid=0.
- DONE: out_valid=1, in_ready=0.
REQ-019 SHALL accept a request on a rising edge with in_valid&&in_ready, capturing a, b, op and word.
REQ-020 SHALL complete ops 0-12 with no BUSY state: IDLE->DONE on the accepting edge, so out_valid is high in the next cycle.
REQ-021 SHALL compute ops 13-19 iteratively, one bit per cycle, over N iterations, where N=32 if word=1 or XLEN=32, else N=64.
REQ-022 SHALL, for ops 13-19, go IDLE->BUSY on the accepting edge and BUSY->DONE on the Nth following edge; out_valid first goes high N+1 cycles after acceptance.
REQ-023 SHALL leave DONE->IDLE on an edge with out_ready=1; res and out_valid SHALL hold stable while out_ready=0.
REQ-024 SHALL use the shift amount b[5:0] when XLEN=64 and word=0, otherwise b[4:0].
REQ-025 SHALL, in word mode, operate on a[31:0] and b[31:0] and sign-extend result bit 31 to XLEN bits; SLT, SLTU, COPY and JALR SHALL ignore word.
REQ-026 SHALL, on divide by zero, return quotient all-ones (DIV/DIVU) and remainder equal to the dividend (REM/REMU).
REQ-027 SHALL, on signed overflow (most-negative / -1), return quotient equal to the most negative value and remainder 0.
REQ-028 SHALL give the remainder the sign of the dividend, and give signed quotients truncated toward zero.
REQ-029 SHALL, when kill=1 on an edge, force the FSM to IDLE and clear out_valid; kill SHALL take priority over acceptance and over completion on that same edge.
REQ-030 SHALL compute zero from the registered res.

Reset
REQ-031 SHALL, with rst_n low, immediately and asynchronously force: state=IDLE, out_valid=0, res=0, zero=1, iteration counter=0 and internal operand registers=0.
REQ-032 SHALL, while rst_n is low, hold in_ready=0; in_ready SHALL return high in the first cycle after rst_n deasserts.
REQ-033 SHALL, when reset is asserted mid-iteration, discard the operation; no result is ever presented for it.

Verification
REQ-034 SHALL cover: ADD, XLEN=64, a=0xFFFFFFFFFFFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, res=0, zero=1.
REQ-035 SHALL cover: word=1 ADD, a=0x7FFFFFFF, b=1 -> res=0xFFFFFFFF80000000; SLT a=-1, b=1 -> res=1; SLTU with the same operands -> res=0.
REQ-036 SHALL cover: DIV a=-7, b=2 -> res=-3 after 65 cycles; REM with the same operands -> res=-1; DIVU a=5, b=0 -> res=all-ones; REM a=5, b=0 -> res=5.
REQ-037 SHALL cover: DIV a=0x8000000000000000, b=-1 -> res=0x8000000000000000; MULHU a=b=all-ones -> res=0xFFFFFFFFFFFFFFFE.
REQ-038 SHALL cover: out_ready held low for 5 cycles in DONE -> res and out_valid stable, in_ready=0; then accepted -> IDLE next cycle.
REQ-039 SHALL cover: kill in cycle 10 of DIV -> IDLE next cycle, no out_valid; rst_n pulsed during MUL -> all outputs at their reset values, next request completes correctly.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU; single-cycle logic/arithmetic ops, bit-serial multiply and divide.
// Word mode works on the low 32 bits and sign-extends the result.
module seq_alu #(
    parameter int XLEN     = 64,
    parameter int OP_WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [OP_WIDTH-1:0] op,
    input  logic                word,
    input  logic                kill,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     res,
    output logic                zero
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [OP_WIDTH-1:0] OP_SUB = OP_WIDTH'(1), OP_AND = OP_WIDTH'(2), OP_OR = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_XOR = OP_WIDTH'(4), OP_SLL = OP_WIDTH'(5), OP_SRL = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_SRA = OP_WIDTH'(7), OP_SLT = OP_WIDTH'(8), OP_SLTU = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_CPA = OP_WIDTH'(10), OP_CPB = OP_WIDTH'(11), OP_JALR = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_MUL = OP_WIDTH'(13), OP_MULH = OP_WIDTH'(14), OP_MULHU = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_DIV = OP_WIDTH'(16), OP_DIVU = OP_WIDTH'(17), OP_REM = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_REMU = OP_WIDTH'(19);
    localparam logic [XLEN-1:0] M32 = XLEN'(32'hFFFF_FFFF);

    function automatic logic [XLEN-1:0] wext(input logic [XLEN-1:0] x, input logic n);
        logic [63:0] t;
        t = {{32{x[31]}}, x[31:0]};
        return n ? t[XLEN-1:0] : x;
    endfunction

    function automatic logic [XLEN-1:0] negn(input logic [XLEN-1:0] x, input logic n);
        return n ? (-x) & M32 : -x;
    endfunction

    state_t                state_q;
    logic                  in_ready_q, out_valid_q, n32_q, neg_q;
    logic [XLEN-1:0]       res_q, q_q;
    logic [2*XLEN-1:0]     p_q, m_q;
    logic [OP_WIDTH-1:0]   op_q;
    logic [6:0]            cnt_q;

    logic                  n32, is_it, is_div, is_rem, sgn, a_neg, b_neg, neg_d, wrap;
    logic [5:0]            sh;
    logic [XLEN-1:0]       aw, bw, ua, ub, a_sr, alu, alu_res, q_init;
    logic [2*XLEN-1:0]     m_init;

    assign n32     = word || XLEN == 32;
    assign is_it   = op >= OP_MUL && op <= OP_REMU;
    assign is_div  = op >= OP_DIV && op <= OP_REMU;
    assign is_rem  = op == OP_REM || op == OP_REMU;
    assign sgn     = op == OP_MULH || op == OP_DIV || op == OP_REM;
    assign a_neg   = sgn && (n32 ? a[31] : a[XLEN-1]);
    assign b_neg   = sgn && (n32 ? b[31] : b[XLEN-1]);
    assign aw      = n32 ? a & M32 : a;
    assign bw      = n32 ? b & M32 : b;
    assign ua      = a_neg ? negn(a, n32) : aw;
    assign ub      = b_neg ? negn(b, n32) : bw;
    assign neg_d   = is_rem ? a_neg : is_div ? (a_neg ^ b_neg) && bw != '0 : a_neg ^ b_neg;
    // dividend is left-aligned so the first N shifts consume exactly its N bits
    assign m_init  = {{XLEN{1'b0}}, is_div ? ub : ua};
    assign q_init  = is_div ? (n32 ? ua << (XLEN - 32) : ua) : ub;
    assign sh      = (XLEN == 64 && !word) ? b[5:0] : {1'b0, b[4:0]};
    assign a_sr    = n32 ? (op == OP_SRA ? wext(a, 1'b1) : a & M32) : a;
    assign wrap    = !(op inside {OP_SLT, OP_SLTU, OP_CPA, OP_CPB, OP_JALR});
    assign alu_res = wrap ? wext(alu, n32) : alu;

    always_comb begin
        alu = a + b;
        case (op)
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            OP_OR:   alu = a | b;
            OP_XOR:  alu = a ^ b;
            OP_SLL:  alu = a << sh;
            OP_SRL:  alu = a_sr >> sh;
            OP_SRA:  alu = $signed(a_sr) >>> sh;
            OP_SLT:  alu = XLEN'($signed(a) < $signed(b));
            OP_SLTU: alu = XLEN'(a < b);
            OP_CPA:  alu = a;
            OP_CPB:  alu = b;
            OP_JALR: alu = (a + b) & {{(XLEN-1){1'b1}}, 1'b0};
            default: ;
        endcase
    end

    logic              it_div, ge;
    logic [XLEN:0]     r_t;
    logic [2*XLEN-1:0] p_s, m_s, prod;
    logic [XLEN-1:0]   q_s, hi, q_fix, r_fix, sel, fin;

    assign it_div = op_q >= OP_DIV;
    assign r_t    = {p_q[XLEN-1:0], q_q[XLEN-1]};
    assign ge     = r_t >= {1'b0, m_q[XLEN-1:0]};
    assign p_s    = it_div ? {{(XLEN-1){1'b0}}, ge ? r_t - {1'b0, m_q[XLEN-1:0]} : r_t}
                           : (q_q[0] ? p_q + m_q : p_q);
    assign m_s    = it_div ? m_q : m_q << 1;
    assign q_s    = it_div ? {q_q[XLEN-2:0], ge} : q_q >> 1;
    assign prod   = neg_q ? -p_s : p_s;
    assign hi     = n32_q ? XLEN'(prod[63:32]) : prod[2*XLEN-1:XLEN];
    assign q_fix  = neg_q ? negn(q_s, n32_q) : q_s;
    assign r_fix  = neg_q ? -p_s[XLEN-1:0] : p_s[XLEN-1:0];
    assign sel    = op_q == OP_MUL ? prod[XLEN-1:0] :
                    (op_q == OP_MULH || op_q == OP_MULHU) ? hi :
                    (op_q == OP_DIV || op_q == OP_DIVU) ? q_fix : r_fix;
    assign fin    = wext(sel, n32_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            m_q         <= '0;
            q_q         <= '0;
            op_q        <= '0;
            n32_q       <= 1'b0;
            neg_q       <= 1'b0;
        end else if (kill) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        op_q        <= op;
                        n32_q       <= n32;
                        neg_q       <= neg_d;
                        p_q         <= '0;
                        m_q         <= m_init;
                        q_q         <= q_init;
                        cnt_q       <= n32 ? 7'd32 : 7'd64;
                        in_ready_q  <= 1'b0;
                        state_q     <= is_it ? BUSY : DONE;
                        out_valid_q <= !is_it;
                        if (!is_it) res_q <= alu_res;
                    end
                end
                BUSY: begin
                    p_q   <= p_s;
                    m_q   <= m_s;
                    q_q   <= q_s;
                    cnt_q <= cnt_q - 7'd1;
                    if (cnt_q == 7'd1) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        res_q       <= fin;
                    end
                end
                DONE: if (out_ready) begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign zero      = res_q == '0;
endmodule
